generation_collector: RTL and testbench

GENERATION_COLLECTOR -- requirements
Module: generation_collector

---
 rtl/conware_pkg.sv | 15 +
 rtl/row_skid_fifo.sv | 54 +++++
 rtl/generation_collector.sv | 132 +++++++++++++
 tb/tb_generation_collector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared types and defaults for the generation collector.
package conware_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StCollect,
    StDrain
  } gc_state_e;

  localparam int unsigned DefaultW  = 8;
  localparam int unsigned DefaultH  = 8;
  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/row_skid_fifo.sv
// Two-entry row buffer between the shredder capture point and the downstream consumer.
module row_skid_fifo
  import conware_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    in_ready  = (cnt_q < 2'(FifoDepth));
    out_valid = (cnt_q != 2'd0);
    out_data  = mem_q[rd_ptr_q];
    count     = cnt_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    mem_d     = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/generation_collector.sv
// Collects one next-generation frame from a shredder row: discards the two priming
// advances, buffers H captured rows and counts live cells.
module generation_collector
  import conware_pkg::*;
#(
  parameter int unsigned W = DefaultW,
  parameter int unsigned H = DefaultH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       adv_in,
  input  logic [W-1:0]               ns_in,
  output logic                       adv_ready,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [W-1:0]               row_data,
  output logic [$clog2(H)-1:0]       row_idx,
  output logic                       row_last,
  output logic [$clog2(W*H+1)-1:0]   live_count,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned IW = $clog2(H);
  localparam int unsigned LW = $clog2(W * H + 1);
  localparam int unsigned RW = $clog2(H + 1);
  localparam int unsigned AW = $clog2(H + 3);
  localparam int unsigned EW = W + IW + 1;
  localparam logic [AW-1:0] AdvMax  = AW'(H + 2);
  localparam logic [RW-1:0] RowLast = RW'(H - 1);
  localparam logic [RW-1:0] RowEnd  = RW'(H);

  gc_state_e       state_q, state_d;
  logic            adv_d_q;
  logic [AW-1:0]   adv_cnt_q, adv_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [LW-1:0]   live_q, live_d;
  logic            err_q, err_d;
  logic            adv_acc, capture;
  logic [1:0]      fifo_cnt;
  logic            fifo_in_ready;
  logic [EW-1:0]   fifo_in_data, fifo_out_data;

  function automatic logic [LW-1:0] popcount(input logic [W-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + LW'(v[i]);
    return c;
  endfunction

  always_comb begin
    adv_ready = ((state_q == StPrime) || (state_q == StCollect)) &&
                (({1'b0, fifo_cnt} + {2'b0, adv_d_q}) < 3'(FifoDepth));
    adv_acc   = adv_in && adv_ready;
    // Advance k lands here with adv_cnt_q == k+1; only k >= 2 carries a real row.
    capture   = (state_q == StCollect) && adv_d_q && (adv_cnt_q >= AW'(3)) &&
                (row_cnt_q < RowEnd) && fifo_in_ready;
    err_d     = err_q | (adv_in & ~adv_ready);
    adv_cnt_d = (adv_acc && (adv_cnt_q != AdvMax)) ? adv_cnt_q + 1'b1 : adv_cnt_q;
    row_cnt_d = row_cnt_q;
    live_d    = live_q;
    if (capture) begin
      row_cnt_d = row_cnt_q + 1'b1;
      live_d    = live_q + popcount(ns_in);
    end
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StPrime;
          adv_cnt_d = '0;
          row_cnt_d = '0;
          live_d    = '0;
        end
      end
      StPrime:   if (adv_acc && (adv_cnt_q == AW'(1))) state_d = StCollect;
      StCollect: if (capture && (row_cnt_q == RowLast)) state_d = StDrain;
      StDrain: begin
        if (!row_valid && !adv_d_q) begin
          state_d    = StIdle;
          frame_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      adv_d_q   <= 1'b0;
      adv_cnt_q <= '0;
      row_cnt_q <= '0;
      live_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adv_d_q   <= adv_acc;
      adv_cnt_q <= adv_cnt_d;
      row_cnt_q <= row_cnt_d;
      live_q    <= live_d;
      err_q     <= err_d;
    end
  end

  assign fifo_in_data = {ns_in, row_cnt_q[IW-1:0], row_cnt_q == RowLast};

  row_skid_fifo #(
    .Width (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (capture),
    .in_data   (fifo_in_data),
    .in_ready  (fifo_in_ready),
    .out_valid (row_valid),
    .out_data  (fifo_out_data),
    .out_ready (row_ready),
    .count     (fifo_cnt)
  );

  assign row_data   = fifo_out_data[EW-1 -: W];
  assign row_idx    = fifo_out_data[IW:1];
  assign row_last   = fifo_out_data[0];
  assign live_count = live_q;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;

endmodule

// File: tb/tb_generation_collector.sv
// Randomised frame-level bench for generation_collector with a queue-based row model.
module tb_generation_collector;

  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         adv_in;
  logic [W-1:0] ns_in;
  logic         adv_ready;
  logic         row_valid;
  logic         row_ready;
  logic [W-1:0] row_data;
  logic [2:0]   row_idx;
  logic         row_last;
  logic [6:0]   live_count;
  logic         frame_done;
  logic         busy;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;
  bit err_exp = 1'b0;

  always #5 clk = ~clk;

  generation_collector #(
    .W (W),
    .H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .adv_in     (adv_in),
    .ns_in      (ns_in),
    .adv_ready  (adv_ready),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .live_count (live_count),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {adv_ready, row_valid, row_data, row_idx, row_last, frame_done, busy},
             32'd0);
    check_eq({tag, "_live"}, 32'(live_count), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One frame from the feeder's point of view: H+2 advances, ns_in presented the cycle after
  // each accepted advance; rows from advances 2..H+1 are expected in order.
  task automatic run_frame(input int rdy_pct, input int stall, input bit violate,
                           input int abort_pops, input bit mid_start, input bit fixed_ns);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] nsv;
    logic [W-1:0] ex;
    int  sent, pops, fd_cnt, live_exp, tail, adv_pct;
    bit  prev_acc, mid_done;
    sent = 0; pops = 0; fd_cnt = 0; live_exp = 0; tail = 0;
    prev_acc = 1'b0; mid_done = 1'b0;
    @(negedge clk);
    start = 1'b1; adv_in = 1'b0; row_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (abort_pops >= 0 && pops >= abort_pops) break;
      if (prev_acc) begin
        nsv   = fixed_ns ? 8'hA5 : W'($urandom);
        ns_in = nsv;
        if (sent - 1 >= 2) begin
          exp_q.push_back(nsv);
          live_exp += $countones(nsv);
        end
      end else begin
        ns_in = W'($urandom);
      end
      row_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      adv_pct   = (fixed_ns || cyc < stall) ? 100 : 70;
      start     = 1'b0;
      if (mid_start && !mid_done && pops == 3) begin
        start    = 1'b1;
        mid_done = 1'b1;
      end
      prev_acc = 1'b0;
      adv_in   = 1'b0;
      if (violate && cyc == stall - 2) begin
        check_eq("viol_ready_low", 32'(adv_ready), 32'd0);
        adv_in = 1'b1;
      end else if (adv_ready && sent < H + 2 && $urandom_range(99) < adv_pct) begin
        adv_in   = 1'b1;
        prev_acc = 1'b1;
        sent++;
      end
      if (stall > 0 && cyc == stall - 1) begin
        check_eq("bp_ready_low", 32'(adv_ready), 32'd0);
        check_eq("bp_row_valid", 32'(row_valid), 32'd1);
        check_eq("bp_adv_sent", 32'(sent), 32'd4);
        if (violate) begin
          check_eq("viol_err_set", 32'(err), 32'd1);
          err_exp = 1'b1;
        end
      end
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("row_unexpected", 32'(row_data), 32'hffff_ffff);
        end else begin
          ex = exp_q.pop_front();
          check_eq("row_data", 32'(row_data), 32'(ex));
          check_eq("row_idx", 32'(row_idx), 32'(pops));
          check_eq("row_last", 32'(row_last), 32'(pops == H - 1));
        end
        pops++;
      end
      if (frame_done) begin
        fd_cnt++;
        check_eq("done_after_all_pops", 32'(pops), 32'(H));
      end
      if (fd_cnt > 0) tail++;
      if (tail > 4) break;
      @(negedge clk);
    end
    start = 1'b0; adv_in = 1'b0;
    if (abort_pops >= 0) begin
      check_eq("abort_no_done", 32'(fd_cnt), 32'd0);
      rst = 1'b1;
      #1;
      check_all_zero("abort_rst");
      @(negedge clk);
      check_all_zero("abort_rst_hold");
      rst = 1'b0;
      err_exp = 1'b0;
    end else begin
      check_eq("frame_done_count", 32'(fd_cnt), 32'd1);
      check_eq("rows_delivered", 32'(pops), 32'(H));
      check_eq("rows_left", 32'(exp_q.size()), 32'd0);
      check_eq("live_count", 32'(live_count), 32'(live_exp));
      check_eq("busy_end", 32'(busy), 32'd0);
      check_eq("err_state", 32'(err), 32'(err_exp));
      repeat (3) @(negedge clk);
      check_eq("live_hold", 32'(live_count), 32'(live_exp));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; adv_in = 1'b0; ns_in = '0; row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    // nominal constant pattern: 8 rows of A5, live 32
    run_frame(100, 0, 1'b0, -1, 1'b0, 1'b1);
    check_eq("nominal_live32", 32'(live_count), 32'd32);
    repeat (4) run_frame(60, 0, 1'b0, -1, 1'b0, 1'b0);
    run_frame(100, 40, 1'b0, -1, 1'b0, 1'b0);
    run_frame(50, 0, 1'b0, -1, 1'b1, 1'b0);
    run_frame(100, 0, 1'b0, 4, 1'b0, 1'b0);
    run_frame(70, 0, 1'b0, -1, 1'b0, 1'b0);
    run_frame(80, 40, 1'b1, -1, 1'b0, 1'b0);
    run_frame(60, 0, 1'b0, -1, 1'b0, 1'b0);
    check_eq("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
    run_frame(60, 0, 1'b0, -1, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
